// File: rtl/caches_types_pkg.sv
// Types shared by the caches and the memory arbiter.
package caches_types_pkg;
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;
    localparam int STARVE_MAX_DEFAULT = 4;
endpackage

// File: rtl/cpu_types_pkg.sv
// Core-wide word and address types shared by the cache hierarchy.
package cpu_types_pkg;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter with synchronous clear; counts data wins over a waiting fetch.
// Updates on the CLK edge; clear dominates increment.
module starve_counter #(
    parameter  int MAX = 4,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/memory_arbiter.sv
// Shares the single-ported RAM between icache and dcache, one access at a time, data first.
// Grant one cycle after request, wait drops on ramready; a request held by its cache stalls until served.
module memory_arbiter
    import caches_types_pkg::*;
#(
    parameter int ADDR_W     = cpu_types_pkg::ADDR_W,
    parameter int DATA_W     = cpu_types_pkg::WORD_W,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    state, next_state;
    logic [SW-1:0] starve;
    logic          starved;
    logic          dreq;
    logic          starve_inc, starve_clr;

    assign dreq    = dREN | dWEN;
    assign starved = (starve == SW'(STARVE_MAX));

    // A data completion only counts against the fetch if the fetch was actually waiting.
    assign starve_inc = (state == DGRANT) && ramready && iREN;
    assign starve_clr = ((state == IGRANT) && ramready) || ((state == IDLE) && !iREN);

    starve_counter #(.MAX(STARVE_MAX)) u_starve (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .count (starve)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        unique case (state)
            IDLE: begin
                if (dreq && (!iREN || !starved)) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = !ramready;
                if (ramready || !iREN) begin
                    next_state = IDLE;
                end
            end
            DGRANT: begin
                ramaddr = daddr;
                // A simultaneous read+write request is a write; no read is issued.
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                dwait = !ramready;
                if (ramready || !dreq) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;
endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
    localparam int SMAX = 4;

    logic        CLK = 1'b0;
    logic        RST, iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    // Reference model: who owns the RAM (0 none, 1 fetch, 2 data) and the starvation tally.
    int m_owner  = 0;
    int m_starve = 0;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [131:0] outs();
        return {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload};
    endfunction

    function automatic logic [131:0] pred();
        logic        ren = 1'b0, wen = 1'b0, iw = 1'b1, dw = 1'b1;
        logic [31:0] a = '0, s = '0;
        if (m_owner == 1) begin
            ren = 1'b1; a = iaddr; iw = !ramready;
        end else if (m_owner == 2) begin
            a = daddr;
            if (dWEN) begin wen = 1'b1; s = dstore; end
            else ren = 1'b1;
            dw = !ramready;
        end
        return {ren, wen, a, s, iw, dw, ramload, ramload};
    endfunction

    // Advance model and DUT across one rising edge using the inputs currently applied.
    task automatic tick();
        int no = m_owner, ns = m_starve;
        if (RST) begin
            no = 0; ns = 0;
        end else if (m_owner == 0) begin
            if ((dREN || dWEN) && (!iREN || m_starve < SMAX)) no = 2;
            else if (iREN) no = 1;
            if (!iREN) ns = 0;
        end else if (m_owner == 1) begin
            if (ramready) begin no = 0; ns = 0; end
            else if (!iREN) no = 0;
        end else begin
            if (ramready) begin
                no = 0;
                if (iREN) ns = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            end else if (!dREN && !dWEN) no = 0;
        end
        @(posedge CLK);
        #1;
        m_owner  = no;
        m_starve = ns;
    endtask

    task automatic idle_in();
        RST = 0; iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = 32'h5A5A_0000;
    endtask

    typedef struct {
        logic        rst, iren;
        logic [31:0] iaddr;
        logic        dren, dwen;
        logic [31:0] daddr, dstore, ramload;
        logic        rdy, chk;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic        iw, dw;
    } vec_t;

    vec_t tbl[14];

    initial begin
        idle_in();
        //            rst iren iaddr        dren dwen daddr       dstore        ramload       rdy chk ren wen addr         store         iw dw
        tbl[0]  = '{1, 0, 32'h0,        0, 0, 32'h0,     32'h0,         32'h1111_0000, 0, 0, 0, 0, 32'h0,     32'h0,         1, 1};
        tbl[1]  = '{0, 1, 32'h40,       0, 0, 32'h0,     32'h0,         32'h1111_0001, 0, 1, 0, 0, 32'h0,     32'h0,         1, 1};
        tbl[2]  = '{0, 1, 32'h40,       0, 0, 32'h0,     32'h0,         32'h0,         0, 1, 1, 0, 32'h40,    32'h0,         1, 1};
        tbl[3]  = '{0, 1, 32'h40,       0, 0, 32'h0,     32'h0,         32'h2408_0001, 1, 1, 1, 0, 32'h40,    32'h0,         0, 1};
        tbl[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,     32'h0,         32'h2408_0001, 0, 1, 0, 0, 32'h0,     32'h0,         1, 1};
        tbl[5]  = '{0, 1, 32'h44,       1, 0, 32'h100,   32'h0,         32'h0,         0, 1, 0, 0, 32'h0,     32'h0,         1, 1};
        tbl[6]  = '{0, 1, 32'h44,       1, 0, 32'h100,   32'h0,         32'hCAFE_0100, 1, 1, 1, 0, 32'h100,   32'h0,         1, 0};
        tbl[7]  = '{0, 1, 32'h44,       0, 0, 32'h0,     32'h0,         32'h0,         0, 1, 0, 0, 32'h0,     32'h0,         1, 1};
        tbl[8]  = '{0, 1, 32'h44,       0, 0, 32'h0,     32'h0,         32'hCAFE_0044, 1, 1, 1, 0, 32'h44,    32'h0,         0, 1};
        tbl[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,     32'h0,         32'h0,         0, 1, 0, 0, 32'h0,     32'h0,         1, 1};
        tbl[10] = '{0, 0, 32'h0,        1, 1, 32'h200,   32'hDEAD_BEEF, 32'h0,         0, 1, 0, 0, 32'h0,     32'h0,         1, 1};
        tbl[11] = '{0, 0, 32'h0,        1, 1, 32'h200,   32'hDEAD_BEEF, 32'h0,         0, 1, 0, 1, 32'h200,   32'hDEAD_BEEF, 1, 1};
        tbl[12] = '{0, 0, 32'h0,        1, 1, 32'h200,   32'hDEAD_BEEF, 32'h7777_0000, 1, 1, 0, 1, 32'h200,   32'hDEAD_BEEF, 1, 0};
        tbl[13] = '{0, 0, 32'h0,        0, 0, 32'h0,     32'h0,         32'h0,         0, 1, 0, 0, 32'h0,     32'h0,         1, 1};

        #2;
        for (int i = 0; i < 14; i++) begin
            RST = tbl[i].rst; iREN = tbl[i].iren; iaddr = tbl[i].iaddr;
            dREN = tbl[i].dren; dWEN = tbl[i].dwen; daddr = tbl[i].daddr;
            dstore = tbl[i].dstore; ramload = tbl[i].ramload; ramready = tbl[i].rdy;
            #1;
            if (tbl[i].chk)
                check($sformatf("vec%0d", i), outs(),
                      {tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].store,
                       tbl[i].iw, tbl[i].dw, tbl[i].ramload, tbl[i].ramload});
            if (i == 1) check("reset_starve", 132'(dut.starve), 132'(0));
            tick();
        end

        // Starvation: fetch held pending while data keeps asking.
        idle_in();
        iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h300;
        for (int k = 0; k < SMAX; k++) begin
            tick();
            #1;
            check($sformatf("starve_dgrant%0d", k), 132'({ramREN, ramWEN, ramaddr, iwait}),
                  132'({1'b1, 1'b0, 32'h300, 1'b1}));
            ramready = 1;
            tick();
            ramready = 0;
            check($sformatf("starve_count%0d", k), 132'(dut.starve), 132'(k + 1));
        end
        tick();
        ramready = 1;
        #1;
        check("starve_forced_igrant", 132'({ramREN, ramaddr, iwait, dwait}),
              132'({1'b1, 32'h80, 1'b0, 1'b1}));
        tick();
        ramready = 0;
        check("starve_cleared", 132'(dut.starve), 132'(0));
        idle_in();
        tick();

        // Fetch abort: iREN withdrawn mid-grant.
        iREN = 1; iaddr = 32'h48;
        tick();
        #1;
        check("abort_grant", 132'({ramREN, ramaddr}), 132'({1'b1, 32'h48}));
        iREN = 0;
        #1;
        check("abort_iwait_hi", 132'(iwait), 132'(1));
        tick();
        check("abort_idle", 132'({ramREN, iwait}), 132'({1'b0, 1'b1}));
        tick();
        check("abort_still_idle", 132'({ramREN, iwait}), 132'({1'b0, 1'b1}));

        // Reset during a write, with a nonzero starvation tally.
        iREN = 1; iaddr = 32'h4C; dWEN = 1; daddr = 32'h204; dstore = 32'h1234_5678;
        tick();
        ramready = 1;
        tick();
        ramready = 0;
        check("rst_pre_count", 132'(dut.starve), 132'(1));
        tick();
        #1;
        check("rst_pre_write", 132'({ramWEN, ramaddr, ramstore}), 132'({1'b1, 32'h204, 32'h1234_5678}));
        RST = 1;
        tick();
        check("rst_mid_write", 132'({ramWEN, ramREN, dwait, iwait, dut.state == caches_types_pkg::IDLE}),
              132'({1'b0, 1'b0, 1'b1, 1'b1, 1'b1}));
        check("rst_count", 132'(dut.starve), 132'(0));
        idle_in();
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            RST      = ($urandom_range(0, 49) == 0);
            iREN     = ($urandom_range(0, 9) < 6);
            dREN     = ($urandom_range(0, 9) < 4);
            dWEN     = ($urandom_range(0, 9) < 3);
            ramready = $urandom_range(0, 1);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            #1;
            check($sformatf("rand_out%0d", c), outs(), pred());
            check($sformatf("rand_cnt%0d", c), 132'(dut.starve), 132'(m_starve));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Arbitrates the instruction cache (iREN/iaddr) and data cache (dREN/dWEN/daddr/dstore) onto the single-ported RAM.
- Returns per-side wait/load signals.
- Sits directly downstream of the icache, between the two caches and the RAM model.
- Serves one transaction at a time. Data has priority, bounded by an instruction anti-starvation counter.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, word width in bits.
- STARVE_MAX, 4, maximum consecutive data grants while an instruction request is pending before instruction is forced.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  synchronous active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  ADDR_W  icache word address.
- iwait  out  1  low for exactly the cycle the instruction word is valid.
- iload  out  DATA_W  instruction word returned.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  ADDR_W  dcache address.
- dstore  in  DATA_W  dcache write data.
- dwait  out  1  low for exactly the completing cycle of a data access.
- dload  out  DATA_W  data word returned.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramready  in  1  RAM completes the current access this cycle.

Behaviour:
- One clock domain (CLK). Reset is synchronous, active-high (RST), sampled only on the rising edge of CLK.
- Reset state:
  - state=IDLE, starve counter=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0.
  - iwait=dwait=1.
  - iload=dload=ramload (pass-through, unqualified).
- States: IDLE, IGRANT, DGRANT.
- Outputs are combinational from the state.
- IDLE: no RAM enables asserted, both waits high. Next state:
  - If dREN|dWEN and (!iREN or starve<STARVE_MAX): go to DGRANT.
  - Else if iREN: go to IGRANT.
  - Else stay in IDLE.
- IGRANT:
  - Drives ramREN=1, ramaddr=iaddr.
  - iwait = !ramready; dwait=1.
  - On ramready: go to IDLE.
  - If iREN drops before ramready (abort): go to IDLE next cycle with no iwait pulse.
- DGRANT:
  - Drives ramaddr=daddr.
  - If dWEN: ramWEN=1, ramstore=dstore, ramREN=0.
  - Else: ramREN=1.
  - dwait = !ramready; iwait=1.
  - On ramready: go to IDLE.
  - If both dREN and dWEN drop: abort to IDLE.
- dREN and dWEN both high: treated as a write. A read is never issued.
- Request address/data change mid-grant: RAM outputs track the live inputs. The caches hold them stable; this block does not latch them.
- Latency:
  - Minimum 2 cycles from request to wait-low (1 cycle IDLE→grant, plus the ramready cycle when RAM is zero-wait).
  - One mandatory IDLE bubble between back-to-back transactions.
- Starve counter:
  - Increments (saturating at STARVE_MAX) when a DGRANT completes while iREN=1.
  - Clears to 0 on IGRANT completion, or when iREN=0 in IDLE.
  - When starve==STARVE_MAX and iREN=1 in IDLE, IGRANT wins regardless of data requests.
- Reset asserted mid-grant: next edge returns to IDLE with enables deasserted. The in-flight RAM access is abandoned and no wait pulse is issued.
- ramready while in IDLE: ignored.

Decomposition:
- Shared caches_types_pkg gains:
  - arb_state_t enum {IDLE, IGRANT, DGRANT}.
  - A localparam for the default STARVE_MAX.
- word_t/ADDR_W come from cpu_types_pkg.
- One natural sub-module: starve_counter (saturating up-counter with clear, width $clog2(STARVE_MAX+1)).
- FSM and output muxing stay in memory_arbiter.

Test Plan:
- Instruction read: RST then iREN=1, iaddr=0x0000_0040, ramready high on the 2nd grant cycle, ramload=0x2408_0001 → ramREN=1 and ramaddr=0x40 during IGRANT; iwait low exactly one cycle with iload=0x2408_0001; then IDLE.
- Simultaneous requests: iREN=1 (iaddr=0x44) and dREN=1 (daddr=0x100) in the same cycle → DGRANT first, ramaddr=0x100; after completion, IDLE bubble, then IGRANT with ramaddr=0x44.
- Write precedence: dREN=dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait low one cycle on ramready.
- Starvation: iREN held at 1 with 5 back-to-back data requests, STARVE_MAX=4 → the first 4 go to DGRANT; the 5th arbitration grants IGRANT; counter reads 0 afterwards.
- Abort: IGRANT entered, iREN dropped before ramready → IDLE next cycle, ramREN=0, iwait never low.
- Reset mid-write: RST=1 during DGRANT with ramWEN=1 → after the next edge ramWEN=0, dwait=1, state IDLE, counter 0.
